// File: rtl/enigma_uart_tx.sv
// enigma_uart_tx: sends Enigma letter codes as ASCII over an 8N1 UART line,
// inserting a space (0x20) between fixed-size letter groups.
module enigma_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int GROUP_SIZE   = 5
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [4:0] LET,
   input  logic       VALID,
   output logic       READY,
   input  logic       GROUP_CLR,
   output logic       TX,
   output logic       BUSY
);

   localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]     GSIZE     = 4'(GROUP_SIZE);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_n;
   logic [BW-1:0] baud, baud_n;
   logic [2:0]    bit_idx, bit_n;
   logic [7:0]    shifter, shift_n;
   logic [7:0]    buf_char;
   logic          buf_full, buf_full_n;
   logic [3:0]    count, count_n;
   logic          tx_n;
   logic          launch;
   logic          send_space;
   logic          accept;

   function automatic logic [7:0] to_ascii(input logic [4:0] code);
      return (code < 5'd26) ? (8'h41 + {3'b000, code}) : 8'h3F;
   endfunction

   assign accept = VALID && READY;

   always_comb begin
      state_n    = state;
      baud_n     = baud;
      bit_n      = bit_idx;
      shift_n    = shifter;
      buf_full_n = buf_full;
      count_n    = GROUP_CLR ? 4'd0 : count;
      launch     = 1'b0;
      send_space = 1'b0;
      tx_n       = 1'b1;

      case (state)
         IDLE: launch = 1'b1;
         START: begin
            if (baud == BAUD_LAST) begin
               baud_n  = '0;
               bit_n   = 3'd0;
               state_n = DATA;
            end else begin
               baud_n = baud + BW'(1);
            end
         end
         DATA: begin
            if (baud == BAUD_LAST) begin
               baud_n = '0;
               if (bit_idx == 3'd7) state_n = STOP;
               else                 bit_n   = bit_idx + 3'd1;
            end else begin
               baud_n = baud + BW'(1);
            end
         end
         STOP: begin
            // The idle decision is folded into the last stop cycle so that
            // back-to-back frames are exactly ten bit times apart.
            if (baud == BAUD_LAST) begin
               baud_n  = '0;
               state_n = IDLE;
               launch  = 1'b1;
            end else begin
               baud_n = baud + BW'(1);
            end
         end
         default: state_n = IDLE;
      endcase

      if (launch && buf_full) begin
         state_n    = START;
         baud_n     = '0;
         bit_n      = 3'd0;
         send_space = (GSIZE != 4'd0) && (count == GSIZE) && !GROUP_CLR;
         if (send_space) begin
            shift_n = 8'h20;
            count_n = 4'd0;
         end else begin
            shift_n    = buf_char;
            buf_full_n = 1'b0;
            count_n    = (count_n >= GSIZE) ? GSIZE : count_n + 4'd1;
         end
      end

      if (accept) buf_full_n = 1'b1;

      case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = shift_n[bit_n];
         default: tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state    <= IDLE;
         baud     <= '0;
         bit_idx  <= 3'd0;
         buf_full <= 1'b0;
         count    <= 4'd0;
         TX       <= 1'b1;
         BUSY     <= 1'b0;
         READY    <= 1'b0;
      end else begin
         state    <= state_n;
         baud     <= baud_n;
         bit_idx  <= bit_n;
         buf_full <= buf_full_n;
         count    <= count_n;
         TX       <= tx_n;
         BUSY     <= (state_n != IDLE) || buf_full_n;
         READY    <= !buf_full_n;
      end
   end

   always_ff @(posedge CLK) begin
      shifter <= shift_n;
      if (accept) buf_char <= to_ascii(LET);
   end

endmodule

// File: tb/tb_enigma_uart_tx.sv
// Scoreboard bench for enigma_uart_tx: two instances (grouping 5 and grouping off),
// serial line decoded by monitors and compared against a queue-based model.
module tb_enigma_uart_tx;

   logic       CLK;
   logic       RESET_N;
   logic [4:0] let5, let0;
   logic       valid5, valid0, clr5, clr0;
   logic       ready5, ready0, tx5, tx0, busy5, busy0;

   int         checks = 0;
   int         passes = 0;
   int         cyc = 0;
   int         cnt5 = 0;
   logic [7:0] q5[$];
   logic [7:0] q0[$];

   enigma_uart_tx #(.CLKS_PER_BIT(4), .GROUP_SIZE(5)) dut5 (
      .CLK(CLK), .RESET_N(RESET_N), .LET(let5), .VALID(valid5), .READY(ready5),
      .GROUP_CLR(clr5), .TX(tx5), .BUSY(busy5));

   enigma_uart_tx #(.CLKS_PER_BIT(4), .GROUP_SIZE(0)) dut0 (
      .CLK(CLK), .RESET_N(RESET_N), .LET(let0), .VALID(valid0), .READY(ready0),
      .GROUP_CLR(clr0), .TX(tx0), .BUSY(busy0));

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(posedge CLK) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, required finish within 40000 cycles");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [7:0] asc(input logic [4:0] c);
      if (c < 5'd26) return 8'h41 + 8'(c);
      return 8'h3F;
   endfunction

   function automatic logic txv(input int d);
      return (d == 0) ? tx5 : tx0;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
   endtask

   // Model of the grouped stream: a space precedes a letter once a full group is out.
   task automatic model5(input logic [4:0] c, input bit clr);
      if (clr) cnt5 = 0;
      if (cnt5 == 5) begin
         q5.push_back(8'h20);
         cnt5 = 0;
      end
      q5.push_back(asc(c));
      cnt5++;
   endtask

   task automatic pulse_clr5();
      clr5 = 1'b1;
      @(negedge CLK);
      clr5 = 1'b0;
      cnt5 = 0;
   endtask

   task automatic send(input int d, input logic [4:0] c, input bit clr);
      int n = 0;
      while (((d == 0) ? ready5 : ready0) == 1'b0 && n < 3000) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 3000) begin
         checks++;
         $display("FAIL send_ready%0d: got READY=0, required 1 within 3000 cycles", d);
         return;
      end
      if (d == 0) begin
         model5(c, clr);
         let5 = c;
         valid5 = 1'b1;
      end else begin
         q0.push_back(asc(c));
         let0 = c;
         valid0 = 1'b1;
      end
      @(negedge CLK);
      valid5 = 1'b0;
      valid0 = 1'b0;
      clr5 = clr;
      @(negedge CLK);
      clr5 = 1'b0;
   endtask

   task automatic wait_idle(input int d);
      int n = 0;
      @(negedge CLK);
      while (((d == 0) ? busy5 : busy0) == 1'b1 && n < 3000) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 3000) begin
         checks++;
         $display("FAIL idle%0d: got BUSY=1, required 0 within 3000 cycles", d);
      end
   endtask

   task automatic wait_cyc(input int n, output bit ab);
      ab = 1'b0;
      for (int k = 0; k < n; k++) begin
         @(negedge CLK);
         if (!RESET_N) ab = 1'b1;
      end
   endtask

   // Serial decoder: samples each bit near its centre; a reset abandons the frame.
   task automatic monitor(input int d);
      logic [7:0] b;
      logic [7:0] e;
      bit         ab;
      forever begin
         @(negedge CLK);
         if (RESET_N && txv(d) == 1'b0) begin
            b = 8'h00;
            wait_cyc(2, ab);
            for (int i = 0; i < 8; i++) begin
               if (!ab) begin
                  wait_cyc(4, ab);
                  b[i] = txv(d);
               end
            end
            if (!ab) wait_cyc(4, ab);
            if (!ab) begin
               chk($sformatf("stop_bit%0d", d), int'(txv(d)), 1);
               if ((d == 0 ? q5.size() : q0.size()) == 0) begin
                  checks++;
                  $display("FAIL unexpected_frame%0d: got 0x%0h, required no frame", d, b);
               end else begin
                  e = (d == 0) ? q5.pop_front() : q0.pop_front();
                  chk($sformatf("char%0d", d), int'(b), int'(e));
               end
            end
         end
      end
   endtask

   initial monitor(0);
   initial monitor(1);

   initial begin
      logic [4:0] ov[0:100];
      int         lows;

      RESET_N = 1'b0;
      let5 = 5'd0; let0 = 5'd0;
      valid5 = 1'b0; valid0 = 1'b0; clr5 = 1'b0; clr0 = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_tx5", int'(tx5), 1);
      chk("rst_busy5", int'(busy5), 0);
      chk("rst_ready5", int'(ready5), 0);
      chk("rst_tx0", int'(tx0), 1);
      chk("rst_ready0", int'(ready0), 0);
      RESET_N = 1'b1;
      @(negedge CLK);
      chk("rel_ready5", int'(ready5), 1);
      chk("rel_ready0", int'(ready0), 1);

      // Single letter 'H': latency and BUSY window
      model5(5'd7, 1'b0);
      let5 = 5'd7; valid5 = 1'b1;
      @(negedge CLK);
      valid5 = 1'b0;
      chk("h_ready_e0", int'(ready5), 0);
      chk("h_tx_e0", int'(tx5), 1);
      @(negedge CLK);
      chk("h_tx_start", int'(tx5), 0);
      chk("h_ready_e1", int'(ready5), 1);
      repeat (39) @(negedge CLK);
      chk("h_busy_e40", int'(busy5), 1);
      @(negedge CLK);
      chk("h_busy_e41", int'(busy5), 0);
      wait_idle(0);

      // Back-to-back 'A','B'
      model5(5'd0, 1'b0);
      let5 = 5'd0; valid5 = 1'b1;
      @(negedge CLK);
      valid5 = 1'b0;
      @(negedge CLK);
      model5(5'd1, 1'b0);
      let5 = 5'd1; valid5 = 1'b1;
      @(negedge CLK);
      valid5 = 1'b0;
      chk("b2b_ready_e2", int'(ready5), 0);
      repeat (38) @(negedge CLK);
      chk("b2b_ready_e40", int'(ready5), 0);
      chk("b2b_stop_e40", int'(tx5), 1);
      @(negedge CLK);
      chk("b2b_ready_e41", int'(ready5), 1);
      chk("b2b_start_e41", int'(tx5), 0);
      wait_idle(0);

      // Grouping: "ABCDE F", then G, clear, five letters, clear coincident with launch
      pulse_clr5();
      for (int i = 0; i < 6; i++) send(0, 5'(i), 1'b0);
      send(0, 5'd6, 1'b0);
      wait_idle(0);
      pulse_clr5();
      for (int i = 21; i < 26; i++) send(0, 5'(i), 1'b0);
      wait_idle(0);
      send(0, 5'd27, 1'b1);
      send(0, 5'd26, 1'b0);
      wait_idle(0);

      // Reset during DATA bit 3 with a letter buffered
      send(0, 5'd0, 1'b0);
      send(0, 5'd25, 1'b0);
      repeat (14) @(negedge CLK);
      chk("mid_bit3", int'(tx5), 0);
      RESET_N = 1'b0;
      @(negedge CLK);
      chk("mid_rst_tx", int'(tx5), 1);
      chk("mid_rst_ready", int'(ready5), 0);
      chk("mid_rst_busy", int'(busy5), 0);
      repeat (2) @(negedge CLK);
      q5.delete();
      cnt5 = 0;
      RESET_N = 1'b1;
      @(negedge CLK);
      chk("mid_rel_ready", int'(ready5), 1);
      lows = 0;
      repeat (60) begin
         @(negedge CLK);
         if (tx5 == 1'b0) lows++;
      end
      chk("mid_no_residual", lows, 0);
      chk("mid_busy_after", int'(busy5), 0);
      send(0, 5'd2, 1'b0);
      wait_idle(0);

      // Grouping disabled: no space ever
      for (int i = 0; i < 12; i++) send(1, 5'($urandom_range(0, 31)), 1'b0);
      wait_idle(1);

      // VALID held high with LET changing every cycle: accepted at edges 0, 2, 42, 82
      for (int k = 0; k <= 100; k++) ov[k] = 5'($urandom_range(0, 31));
      q0.push_back(asc(ov[0]));
      q0.push_back(asc(ov[2]));
      q0.push_back(asc(ov[42]));
      q0.push_back(asc(ov[82]));
      for (int k = 0; k <= 100; k++) begin
         let0 = ov[k];
         valid0 = 1'b1;
         @(negedge CLK);
      end
      valid0 = 1'b0;
      wait_idle(1);

      // Randomized traffic on the grouped instance
      for (int i = 0; i < 20; i++) begin
         repeat ($urandom_range(0, 50)) @(negedge CLK);
         if ($urandom_range(0, 4) == 0) begin
            wait_idle(0);
            pulse_clr5();
         end
         send(0, 5'($urandom_range(0, 31)), 1'b0);
      end

      wait_idle(0);
      wait_idle(1);
      repeat (10) @(negedge CLK);
      chk("q5_drained", q5.size(), 0);
      chk("q0_drained", q0.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/enigma_uart_tx.md
Name: enigma_uart_tx

Overview:
- Output-side counterpart to the Enigma letter path. The Enigma consumes 5-bit letter codes and produces encrypted 5-bit codes; this block takes those codes and sends them as ASCII over a UART 8N1 serial line.
- Letters are output in the classic Enigma five-letter groups, with a space inserted between groups.
- Sits after the inverse plugboard, in parallel with the seven-segment display path. It is fed by a one-cycle strobe derived from the debounced ENTER.

Parameters:
- CLKS_PER_BIT, 868, CLK cycles per serial bit (100 MHz / 115200). Legal range ≥2.
- GROUP_SIZE, 5, letters per group before an inserted space (0x20). 0 disables space insertion. Legal range 0..15.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  synchronous reset, active low.
- LET  in  5  letter code: 0='A' .. 25='Z'.
- VALID  in  1  LET is offered this cycle.
- READY  out  1  holding buffer empty; a letter is accepted on any cycle where VALID&&READY.
- GROUP_CLR  in  1  synchronous pulse; restarts grouping at letter 0.
- TX  out  1  serial output; idles high.
- BUSY  out  1  high while a frame is on the line or the buffer is occupied.

Behaviour:
- Clock and reset:
  - One clock, CLK. Reset is synchronous and active-low (RESET_N sampled on CLK rising edge).
  - While RESET_N=0: TX=1, BUSY=0, READY=0, buffer empty, group count=0, FSM=IDLE, bit/baud counters=0.
  - First cycle after release: READY=1.
  - Reset mid-frame aborts immediately: TX returns high on the next edge, and any buffered letter is discarded.
- All outputs are registered.
- Character mapping:
  - Codes 0..25 map to 8'h41+LET.
  - Codes 26..31 map to '?' (8'h3F). These count toward the group like letters.
- Holding buffer: one entry (8-bit char + is_letter flag).
  - READY = buffer empty (outside reset).
  - VALID while READY=0 is ignored; no error flag and no queueing beyond one entry.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - Buffer empty: stay in IDLE, TX=1.
  - Buffer full and GROUP_SIZE≠0 and count==GROUP_SIZE: load shifter with 0x20, count←0, letter stays in buffer; go to START.
  - Buffer full otherwise: move buffer to shifter, count←count+1, buffer←empty; go to START.
- START: TX=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; bit index 0..7. After bit 7, go to STOP.
- STOP: TX=1 for CLKS_PER_BIT cycles. Then go to IDLE, which is evaluated in the same cycle.
  - If the buffer is full, START begins on the next edge.
  - Back-to-back frames therefore have no extra idle bit: frame period = 10*CLKS_PER_BIT cycles exactly.
- Latency: letter accepted at edge e0 (idle, empty buffer) → START entered at e1, TX=0 after e1. READY returns high after e1, so a second letter can queue during the first frame.
- Space rules:
  - A space is sent only when a next letter is pending, so there is never a trailing space.
  - The space frame delays the pending letter by exactly one frame.
- GROUP_CLR:
  - Forces count←0 on that edge.
  - If coincident with the IDLE decision, the clear wins: no space is inserted, the letter is sent, and count becomes 1.
  - A frame already in flight is unaffected.
- Counters:
  - Baud counter is ⌈log2(CLKS_PER_BIT)⌉ bits and wraps to 0 at CLKS_PER_BIT-1.
  - Bit index is 3 bits.
  - Group count is 4 bits and saturates at GROUP_SIZE (cannot exceed it).
- BUSY = (FSM≠IDLE) || buffer full.
- VALID held high continuously: a new letter is accepted each time READY rises, i.e. one per frame.

Test Plan:
- Single letter, CLKS_PER_BIT=4: reset, then LET=7, VALID 1 cycle → TX low 1 cycle after accept. Bits 0,0,0,1,0,0,1,0 ('H'=0x48), each 4 cycles. Stop high 4 cycles. BUSY high for exactly 40 cycles after e1.
- Back-to-back: LET=0 then LET=1 offered while first is sending → ASCII 'A','B'. Second start bit immediately after first stop (period 40 cycles). READY low only while buffer holds 'B'.
- Grouping, GROUP_SIZE=5: six codes 0..5 → line carries "ABCDE F" (7 frames, 0x20 sixth). A seventh letter after GROUP_CLR mid-group restarts the count; no space before the next 5.
- Invalid code: LET=27 → 0x3F sent and counted. GROUP_SIZE=0 with 12 letters → no 0x20 ever.
- Reset mid-frame: assert RESET_N=0 during DATA bit 3 with a letter buffered → TX=1, READY=0, BUSY=0 next edge. After release, no residual frame; a new letter transmits normally.
- Overflow: VALID held high with LET changing every cycle → only the letters present on READY-high cycles are transmitted, each as a complete frame.
